// File: rtl/regfile_wb_arbiter.sv
// Register-file write-port arbiter shared by pipeline writeback, a buffered
// multiply/divide result stream and the debug port; also tracks MDU RAW hazards.
module regfile_wb_arbiter #(
  parameter int unsigned MDU_FIFO_DEPTH = 2,
  parameter int unsigned STARVE_LIMIT   = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        wb_we,
  input  logic [4:0]  wb_addr,
  input  logic [31:0] wb_data,
  output logic        wb_hold,
  input  logic        mdu_issue,
  input  logic [4:0]  mdu_issue_addr,
  input  logic        mdu_valid,
  output logic        mdu_ready,
  input  logic [4:0]  mdu_addr,
  input  logic [31:0] mdu_data,
  input  logic        dbg_req,
  input  logic [4:0]  dbg_addr,
  input  logic [31:0] dbg_wdata,
  output logic        dbg_ack,
  input  logic [4:0]  rs_addr,
  input  logic [4:0]  rt_addr,
  output logic        hazard_stall,
  output logic        rf_we,
  output logic [4:0]  rf_waddr,
  output logic [31:0] rf_wdata
);

  localparam int unsigned PW = (MDU_FIFO_DEPTH > 1) ? $clog2(MDU_FIFO_DEPTH) : 1;
  localparam int unsigned CW = PW + 1;
  localparam int unsigned SW = $clog2(STARVE_LIMIT + 1);

  typedef enum logic [1:0] {SRC_NONE, SRC_WB, SRC_FIFO, SRC_DBG} src_t;

  logic [4:0]    fifo_addr [MDU_FIFO_DEPTH];
  logic [31:0]   fifo_data [MDU_FIFO_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic [31:0]   busy, busy_next;
  logic [SW-1:0] starve_cnt, starve_next;
  logic          hold, hold_next;
  logic          fifo_empty, fifo_full, push, pop, starved;
  src_t          grant;

  assign fifo_empty = (count == '0);
  assign fifo_full  = (count == CW'(MDU_FIFO_DEPTH));
  assign mdu_ready  = !fifo_full;
  assign push       = mdu_valid && mdu_ready;
  assign pop        = (grant == SRC_FIFO);

  always_comb begin
    grant = SRC_NONE;
    if (hold)             grant = SRC_FIFO;
    else if (wb_we)       grant = SRC_WB;
    else if (!fifo_empty) grant = SRC_FIFO;
    else if (dbg_req)     grant = SRC_DBG;
  end

  always_comb begin
    rf_waddr = '0;
    rf_wdata = '0;
    unique case (grant)
      SRC_WB:   begin rf_waddr = wb_addr;           rf_wdata = wb_data;           end
      SRC_FIFO: begin rf_waddr = fifo_addr[rd_ptr]; rf_wdata = fifo_data[rd_ptr]; end
      SRC_DBG:  begin rf_waddr = dbg_addr;          rf_wdata = dbg_wdata;         end
      default:  ;
    endcase
  end

  // Combinational outputs are gated by reset so nothing writes while it is held.
  assign rf_we        = reset && (grant != SRC_NONE) && (rf_waddr != '0);
  assign dbg_ack      = reset && (grant == SRC_DBG);
  assign wb_hold      = hold;
  assign hazard_stall = ((rs_addr != '0) && busy[rs_addr]) ||
                        ((rt_addr != '0) && busy[rt_addr]);

  always_comb begin
    busy_next = busy;
    if (pop) busy_next[fifo_addr[rd_ptr]] = 1'b0;
    if (mdu_issue && (mdu_issue_addr != '0)) busy_next[mdu_issue_addr] = 1'b1;
    busy_next[0] = 1'b0;
  end

  // Hold arms on the edge where the count reaches the limit, so WB is held
  // after exactly STARVE_LIMIT ungranted cycles.
  always_comb begin
    starved     = !fifo_empty && !pop;
    starve_next = '0;
    if (starved)
      starve_next = (starve_cnt == SW'(STARVE_LIMIT)) ? starve_cnt : starve_cnt + 1'b1;
    hold_next = !hold && starved && (starve_next == SW'(STARVE_LIMIT));
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      busy       <= '0;
      starve_cnt <= '0;
      hold       <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (!push && pop) count <= count - 1'b1;
      busy       <= busy_next;
      starve_cnt <= starve_next;
      hold       <= hold_next;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_addr[wr_ptr] <= mdu_addr;
      fifo_data[wr_ptr] <= mdu_data;
    end
  end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: each task drives one scenario and
// checks the write port and side outputs against hand-computed values.
module tb_regfile_wb_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        wb_we;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        wb_hold;
  logic        mdu_issue;
  logic [4:0]  mdu_issue_addr;
  logic        mdu_valid;
  logic        mdu_ready;
  logic [4:0]  mdu_addr;
  logic [31:0] mdu_data;
  logic        dbg_req;
  logic [4:0]  dbg_addr;
  logic [31:0] dbg_wdata;
  logic        dbg_ack;
  logic [4:0]  rs_addr;
  logic [4:0]  rt_addr;
  logic        hazard_stall;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  regfile_wb_arbiter #(.MDU_FIFO_DEPTH(2), .STARVE_LIMIT(4)) dut (
    .clk(clk), .reset(reset),
    .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data), .wb_hold(wb_hold),
    .mdu_issue(mdu_issue), .mdu_issue_addr(mdu_issue_addr),
    .mdu_valid(mdu_valid), .mdu_ready(mdu_ready), .mdu_addr(mdu_addr), .mdu_data(mdu_data),
    .dbg_req(dbg_req), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata), .dbg_ack(dbg_ack),
    .rs_addr(rs_addr), .rt_addr(rt_addr), .hazard_stall(hazard_stall),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata)
  );

  // Inputs change 1 ns after the rising edge; outputs are sampled on the falling edge.
  task automatic to_sample();
    @(negedge clk);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    wb_we = 0; wb_addr = 0; wb_data = 0;
    mdu_issue = 0; mdu_issue_addr = 0;
    mdu_valid = 0; mdu_addr = 0; mdu_data = 0;
    dbg_req = 0; dbg_addr = 0; dbg_wdata = 0;
    rs_addr = 0; rt_addr = 0;
  endtask

  task automatic check_write(input string name, input logic we, input logic [4:0] a,
                             input logic [31:0] d);
    checks++;
    if (rf_we !== we || (we && (rf_waddr !== a || rf_wdata !== d))) begin
      errors++;
      $display("FAIL %s: rf_we=%0b waddr=%0d wdata=%h, expected we=%0b waddr=%0d wdata=%h",
               name, rf_we, rf_waddr, rf_wdata, we, a, d);
    end
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 0;
    wb_we = 1; wb_addr = 7; wb_data = 32'h77;
    to_sample();
    check_write("reset_no_write", 0, 0, 0);
    next_cycle();
    next_cycle();
    wb_we = 0;
    reset = 1;
    to_sample();
    checks++;
    if ({rf_we, wb_hold, hazard_stall, mdu_ready, dbg_ack} !== 5'b00010) begin
      errors++;
      $display("FAIL reset_idle: we/hold/haz/ready/ack=%b, expected 00010",
               {rf_we, wb_hold, hazard_stall, mdu_ready, dbg_ack});
    end
    next_cycle();
  endtask

  task automatic test_wb_only();
    wb_we = 1; wb_addr = 5; wb_data = 32'hDEADBEEF;
    to_sample();
    check_write("wb_write", 1, 5, 32'hDEADBEEF);
    next_cycle();
    wb_addr = 0;
    to_sample();
    check_write("wb_addr0", 0, 0, 0);
    next_cycle();
    wb_we = 0;
  endtask

  task automatic test_mdu_scoreboard();
    mdu_issue = 1; mdu_issue_addr = 8; rs_addr = 8;
    to_sample();
    checks++;
    if (hazard_stall !== 1'b0) begin
      errors++; $display("FAIL haz_issue_cycle: hazard_stall=%b expected 0", hazard_stall);
    end
    next_cycle();
    mdu_issue = 0;
    to_sample();
    checks++;
    if (hazard_stall !== 1'b1) begin
      errors++; $display("FAIL haz_after_issue: hazard_stall=%b expected 1", hazard_stall);
    end
    next_cycle();
    mdu_valid = 1; mdu_addr = 8; mdu_data = 32'h1234;
    rs_addr = 0; rt_addr = 8;
    to_sample();
    check_write("mdu_no_bypass", 0, 0, 0);
    checks++;
    if (hazard_stall !== 1'b1) begin
      errors++; $display("FAIL haz_rt_push: hazard_stall=%b expected 1", hazard_stall);
    end
    next_cycle();
    mdu_valid = 0;
    to_sample();
    check_write("mdu_write", 1, 8, 32'h1234);
    next_cycle();
    to_sample();
    checks++;
    if (hazard_stall !== 1'b0) begin
      errors++; $display("FAIL haz_cleared: hazard_stall=%b expected 0", hazard_stall);
    end
    next_cycle();
    rt_addr = 0;
  endtask

  task automatic test_starvation();
    wb_we = 1; wb_addr = 10; wb_data = 32'h1111;
    mdu_valid = 1; mdu_addr = 12; mdu_data = 32'h2222;
    to_sample();
    check_write("starve_push_cycle", 1, 10, 32'h1111);
    next_cycle();
    mdu_valid = 0;
    for (int i = 1; i <= 4; i++) begin
      to_sample();
      checks++;
      if (wb_hold !== 1'b0 || rf_waddr !== 5'd10) begin
        errors++;
        $display("FAIL starve_wait%0d: wb_hold=%b waddr=%0d expected 0/10", i, wb_hold, rf_waddr);
      end
      next_cycle();
    end
    to_sample();
    checks++;
    if (wb_hold !== 1'b1) begin
      errors++; $display("FAIL starve_hold: wb_hold=%b expected 1", wb_hold);
    end
    check_write("starve_mdu_write", 1, 12, 32'h2222);
    next_cycle();
    to_sample();
    checks++;
    if (wb_hold !== 1'b0) begin
      errors++; $display("FAIL starve_hold_once: wb_hold=%b expected 0", wb_hold);
    end
    check_write("starve_wb_resume", 1, 10, 32'h1111);
    next_cycle();
    wb_we = 0;
  endtask

  task automatic test_fifo_full();
    logic [4:0]  exp_a [3];
    logic [31:0] exp_d [3];
    exp_a[0] = 20; exp_a[1] = 21; exp_a[2] = 22;
    exp_d[0] = 32'hA0; exp_d[1] = 32'hB1; exp_d[2] = 32'hC2;
    wb_we = 1; wb_addr = 4; wb_data = 32'h44;
    mdu_valid = 1; mdu_addr = exp_a[0]; mdu_data = exp_d[0];
    to_sample();
    checks++;
    if (mdu_ready !== 1'b1) begin
      errors++; $display("FAIL full_ready0: mdu_ready=%b expected 1", mdu_ready);
    end
    next_cycle();
    mdu_addr = exp_a[1]; mdu_data = exp_d[1];
    to_sample();
    checks++;
    if (mdu_ready !== 1'b1) begin
      errors++; $display("FAIL full_ready1: mdu_ready=%b expected 1", mdu_ready);
    end
    next_cycle();
    mdu_addr = exp_a[2]; mdu_data = exp_d[2];
    for (int i = 0; i < 2; i++) begin
      to_sample();
      checks++;
      if (mdu_ready !== 1'b0) begin
        errors++; $display("FAIL full_ready_low%0d: mdu_ready=%b expected 0", i, mdu_ready);
      end
      next_cycle();
    end
    wb_we = 0;
    to_sample();
    check_write("full_pop0", 1, exp_a[0], exp_d[0]);
    checks++;
    if (mdu_ready !== 1'b0) begin
      errors++; $display("FAIL full_ready_pop: mdu_ready=%b expected 0", mdu_ready);
    end
    next_cycle();
    to_sample();
    checks++;
    if (mdu_ready !== 1'b1) begin
      errors++; $display("FAIL full_ready_after_pop: mdu_ready=%b expected 1", mdu_ready);
    end
    check_write("full_pop1", 1, exp_a[1], exp_d[1]);
    next_cycle();
    mdu_valid = 0;
    to_sample();
    check_write("full_pop2", 1, exp_a[2], exp_d[2]);
    next_cycle();
    to_sample();
    check_write("full_drained", 0, 0, 0);
    next_cycle();
  endtask

  task automatic test_debug();
    int budget;
    wb_we = 1; wb_addr = 6; wb_data = 32'h66;
    dbg_req = 1; dbg_addr = 3; dbg_wdata = 32'hA5A5A5A5;
    for (int i = 0; i < 3; i++) begin
      to_sample();
      checks++;
      if (dbg_ack !== 1'b0 || rf_waddr !== 5'd6) begin
        errors++;
        $display("FAIL dbg_blocked%0d: dbg_ack=%b waddr=%0d expected 0/6", i, dbg_ack, rf_waddr);
      end
      next_cycle();
    end
    wb_we = 0;
    to_sample();
    checks++;
    if (dbg_ack !== 1'b1) begin
      errors++; $display("FAIL dbg_ack: dbg_ack=%b expected 1", dbg_ack);
    end
    check_write("dbg_write", 1, 3, 32'hA5A5A5A5);
    next_cycle();
    dbg_req = 0;
    to_sample();
    checks++;
    if (dbg_ack !== 1'b0) begin
      errors++; $display("FAIL dbg_ack_pulse: dbg_ack=%b expected 0", dbg_ack);
    end
    next_cycle();
    // Address-0 MDU result is popped without a write, then debug may proceed.
    mdu_valid = 1; mdu_addr = 0; mdu_data = 32'hFFFF;
    dbg_req = 1; dbg_addr = 0; dbg_wdata = 32'h5;
    next_cycle();
    mdu_valid = 0;
    to_sample();
    checks++;
    if (rf_we !== 1'b0 || dbg_ack !== 1'b0) begin
      errors++; $display("FAIL mdu_addr0_pop: rf_we=%b dbg_ack=%b expected 0/0", rf_we, dbg_ack);
    end
    next_cycle();
    budget = 0;
    while (dbg_ack !== 1'b1 && budget < 5) begin
      budget++;
      next_cycle();
    end
    to_sample();
    checks++;
    if (dbg_ack !== 1'b1 || rf_we !== 1'b0 || budget != 0) begin
      errors++;
      $display("FAIL dbg_addr0: dbg_ack=%b rf_we=%b wait=%0d expected 1/0/0", dbg_ack, rf_we, budget);
    end
    next_cycle();
    dbg_req = 0;
  endtask

  task automatic test_mid_reset();
    mdu_issue = 1; mdu_issue_addr = 9;
    mdu_valid = 1; mdu_addr = 9; mdu_data = 32'h99;
    rs_addr = 9;
    next_cycle();
    mdu_issue = 0; mdu_valid = 0;
    reset = 0;
    to_sample();
    check_write("midreset_no_write", 0, 0, 0);
    checks++;
    if (hazard_stall !== 1'b0) begin
      errors++; $display("FAIL midreset_busy: hazard_stall=%b expected 0", hazard_stall);
    end
    next_cycle();
    reset = 1;
    to_sample();
    check_write("midreset_fifo_flushed", 0, 0, 0);
    next_cycle();
    rs_addr = 0;
  endtask

  initial begin
    test_reset();
    test_wb_only();
    test_mdu_scoreboard();
    test_starvation();
    test_fifo_full();
    test_debug();
    test_mid_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
